// File: rtl/ud_counter_bus_host_if.sv
// System-side command interface of the counter bus host: request, status and read data.
// The sequencer uses the master view; the bus host uses the slave view.
interface ud_counter_bus_host_if;
  logic       req;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       start_req;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output req, rw, addr, wdata, start_req,
    input  busy, done, rdata
  );

  modport slave (
    input  req, rw, addr, wdata, start_req,
    output busy, done, rdata
  );
endinterface

// File: rtl/ud_counter_bus_host.sv
// Turns single-cycle commands into registered ncs/nwr/nrd/A1A0/din bus cycles and start pulses.
// Access: done at STROBE_CYCLES+3 after acceptance; start: START_CYCLES+1. Requests are accepted only in IDLE.
module ud_counter_bus_host #(
  parameter int STROBE_CYCLES = 1,
  parameter int START_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ud_counter_bus_host_if.slave    bus,
  output logic                    ncs,
  output logic                    nwr,
  output logic                    nrd,
  output logic                    A0,
  output logic                    A1,
  inout  wire  [7:0]              din,
  output logic                    start
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    PULSE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ncs_q, ncs_d;
  logic       nwr_q, nwr_d;
  logic       nrd_q, nrd_d;
  logic       oe_q, oe_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       on_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      ncs_q   <= 1'b1;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
      oe_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      nwr_q   <= nwr_d;
      nrd_q   <= nrd_d;
      oe_q    <= oe_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A bus access outranks a simultaneous start request, which is dropped.
        if (bus.req) begin
          state_d = SETUP;
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end else if (bus.start_req) begin
          state_d = PULSE;
          cnt_d   = 4'(START_CYCLES - 1);
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (rw_q) begin
            rdata_d = din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin values are registered from the next state so they change exactly at state entry.
    on_bus  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    ncs_d   = !on_bus;
    nwr_d   = !((state_d == STROBE) && !rw_d);
    nrd_d   = !((state_d == STROBE) && rw_d);
    oe_d    = on_bus && !rw_d;
    start_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
  end

  assign din       = oe_q ? wdata_q : 8'hzz;
  assign ncs       = ncs_q;
  assign nwr       = nwr_q;
  assign nrd       = nrd_q;
  assign A0        = addr_q[0];
  assign A1        = addr_q[1];
  assign start     = start_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ud_counter_bus_host.sv
// Directed bench for the counter bus host; an undriven data bus is pulled up and reads as 8'hFF.
module tb_ud_counter_bus_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance 1: STROBE_CYCLES=1, START_CYCLES=1
  ud_counter_bus_host_if bus1 ();
  logic ncs1, nwr1, nrd1, a0_1, a1_1, start1;
  wire  [7:0] din1;
  logic       rsp1_en  = 1'b0;
  logic [7:0] rsp1_val = 8'h00;
  assign din1 = (rsp1_en && !ncs1 && !nrd1) ? rsp1_val : 8'hzz;

  // Instance 2: STROBE_CYCLES=3
  ud_counter_bus_host_if bus3 ();
  logic ncs3, nwr3, nrd3, a0_3, a1_3, start3;
  wire  [7:0] din3;
  logic       rsp3_en  = 1'b0;
  logic [7:0] rsp3_val = 8'h00;
  assign din3 = (rsp3_en && !ncs3 && !nrd3) ? rsp3_val : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (din1[g]);
    pullup (din3[g]);
  end

  ud_counter_bus_host #(.STROBE_CYCLES(1), .START_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .ncs(ncs1), .nwr(nwr1), .nrd(nrd1), .A0(a0_1), .A1(a1_1),
    .din(din1), .start(start1)
  );

  ud_counter_bus_host #(.STROBE_CYCLES(3), .START_CYCLES(1)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .ncs(ncs3), .nwr(nwr3), .nrd(nrd3), .A0(a0_3), .A1(a1_3),
    .din(din3), .start(start3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] seq_addr [3];
  logic [7:0] seq_data [3];

  initial begin
    bus1.req = 0; bus1.rw = 0; bus1.addr = 0; bus1.wdata = 0; bus1.start_req = 0;
    bus3.req = 0; bus3.rw = 0; bus3.addr = 0; bus3.wdata = 0; bus3.start_req = 0;
    seq_addr[0] = 2'd1; seq_data[0] = 8'd6;
    seq_addr[1] = 2'd2; seq_data[1] = 8'd2;
    seq_addr[2] = 2'd3; seq_data[2] = 8'd4;

    // Reset state
    tick(); tick();
    chk("rst_ncs", {7'd0, ncs1}, 8'd1);
    chk("rst_nwr", {7'd0, nwr1}, 8'd1);
    chk("rst_nrd", {7'd0, nrd1}, 8'd1);
    chk("rst_addr", {6'd0, a1_1, a0_1}, 8'd0);
    chk("rst_start", {7'd0, start1}, 8'd0);
    chk("rst_busy", {7'd0, bus1.busy}, 8'd0);
    chk("rst_done", {7'd0, bus1.done}, 8'd0);
    chk("rst_rdata", bus1.rdata, 8'h00);
    chk("rst_din", din1, 8'hFF);
    rst = 0;

    // Single write, addr 0, data 4
    bus1.req = 1; bus1.rw = 0; bus1.addr = 2'd0; bus1.wdata = 8'd4;
    tick();
    bus1.req = 0;
    chk("wr_setup_ncs", {7'd0, ncs1}, 8'd0);
    chk("wr_setup_nwr", {7'd0, nwr1}, 8'd1);
    chk("wr_setup_addr", {6'd0, a1_1, a0_1}, 8'd0);
    chk("wr_setup_din", din1, 8'd4);
    chk("wr_setup_busy", {7'd0, bus1.busy}, 8'd1);
    tick();
    chk("wr_strobe_nwr", {7'd0, nwr1}, 8'd0);
    chk("wr_strobe_nrd", {7'd0, nrd1}, 8'd1);
    chk("wr_strobe_din", din1, 8'd4);
    tick();
    chk("wr_hold_nwr", {7'd0, nwr1}, 8'd1);
    chk("wr_hold_ncs", {7'd0, ncs1}, 8'd0);
    chk("wr_hold_din", din1, 8'd4);
    chk("wr_hold_done", {7'd0, bus1.done}, 8'd0);
    tick();
    chk("wr_end_done", {7'd0, bus1.done}, 8'd1);
    chk("wr_end_ncs", {7'd0, ncs1}, 8'd1);
    chk("wr_end_busy", {7'd0, bus1.busy}, 8'd0);
    chk("wr_end_din", din1, 8'hFF);

    // Back-to-back register setup writes, each issued in the done cycle
    for (int i = 0; i < 3; i++) begin
      bus1.req = 1; bus1.rw = 0; bus1.addr = seq_addr[i]; bus1.wdata = seq_data[i];
      tick();
      bus1.req = 0;
      chk("seq_setup_ncs", {7'd0, ncs1}, 8'd0);
      chk("seq_setup_nwr", {7'd0, nwr1}, 8'd1);
      tick();
      chk("seq_strobe_nwr", {7'd0, nwr1}, 8'd0);
      chk("seq_strobe_nrd", {7'd0, nrd1}, 8'd1);
      chk("seq_strobe_addr", {6'd0, a1_1, a0_1}, {6'd0, seq_addr[i]});
      chk("seq_strobe_din", din1, seq_data[i]);
      tick();
      chk("seq_hold_nwr", {7'd0, nwr1}, 8'd1);
      tick();
      chk("seq_done", {7'd0, bus1.done}, 8'd1);
      chk("seq_gap_ncs", {7'd0, ncs1}, 8'd1);
      chk("seq_keep_addr", {6'd0, a1_1, a0_1}, {6'd0, seq_addr[i]});
    end

    // Read of addr 2, responder drives 8'h02 only while nrd is low
    rsp1_en = 1; rsp1_val = 8'h02;
    bus1.req = 1; bus1.rw = 1; bus1.addr = 2'd2;
    tick();
    bus1.req = 0;
    chk("rd_setup_ncs", {7'd0, ncs1}, 8'd0);
    chk("rd_setup_nrd", {7'd0, nrd1}, 8'd1);
    chk("rd_setup_din", din1, 8'hFF);
    tick();
    chk("rd_strobe_nrd", {7'd0, nrd1}, 8'd0);
    chk("rd_strobe_nwr", {7'd0, nwr1}, 8'd1);
    chk("rd_strobe_addr", {6'd0, a1_1, a0_1}, 8'd2);
    chk("rd_strobe_din", din1, 8'h02);
    tick();
    chk("rd_hold_nrd", {7'd0, nrd1}, 8'd1);
    chk("rd_hold_din", din1, 8'hFF);
    tick();
    chk("rd_done", {7'd0, bus1.done}, 8'd1);
    chk("rd_rdata", bus1.rdata, 8'h02);
    chk("rd_end_din", din1, 8'hFF);
    tick();
    chk("rd_done_clear", {7'd0, bus1.done}, 8'd0);
    chk("rd_rdata_held", bus1.rdata, 8'h02);
    rsp1_en = 0;

    // Start pulse alone
    bus1.start_req = 1;
    tick();
    bus1.start_req = 0;
    chk("st_start", {7'd0, start1}, 8'd1);
    chk("st_ncs", {7'd0, ncs1}, 8'd1);
    chk("st_busy", {7'd0, bus1.busy}, 8'd1);
    tick();
    chk("st_end_start", {7'd0, start1}, 8'd0);
    chk("st_done", {7'd0, bus1.done}, 8'd1);
    chk("st_end_ncs", {7'd0, ncs1}, 8'd1);

    // req and start_req together: access wins; requests while busy ignored
    bus1.req = 1; bus1.rw = 0; bus1.addr = 2'd3; bus1.wdata = 8'h09; bus1.start_req = 1;
    tick();
    bus1.req = 0; bus1.start_req = 0;
    chk("pri_setup_ncs", {7'd0, ncs1}, 8'd0);
    chk("pri_setup_start", {7'd0, start1}, 8'd0);
    bus1.req = 1; bus1.rw = 1; bus1.addr = 2'd1; bus1.start_req = 1;
    tick();
    chk("pri_strobe_nwr", {7'd0, nwr1}, 8'd0);
    chk("pri_strobe_nrd", {7'd0, nrd1}, 8'd1);
    chk("pri_strobe_din", din1, 8'h09);
    tick();
    bus1.req = 0; bus1.start_req = 0;
    chk("pri_hold_addr", {6'd0, a1_1, a0_1}, 8'd3);
    chk("pri_hold_start", {7'd0, start1}, 8'd0);
    tick();
    chk("pri_done", {7'd0, bus1.done}, 8'd1);
    chk("pri_rdata_kept", bus1.rdata, 8'h02);
    tick();
    chk("pri_idle_ncs", {7'd0, ncs1}, 8'd1);
    chk("pri_idle_busy", {7'd0, bus1.busy}, 8'd0);
    chk("pri_idle_start", {7'd0, start1}, 8'd0);

    // Reset asserted during STROBE of a write
    bus1.req = 1; bus1.rw = 0; bus1.addr = 2'd1; bus1.wdata = 8'h07;
    tick();
    bus1.req = 0;
    tick();
    chk("rw_strobe_nwr", {7'd0, nwr1}, 8'd0);
    rst = 1;
    tick();
    chk("rw_nwr", {7'd0, nwr1}, 8'd1);
    chk("rw_ncs", {7'd0, ncs1}, 8'd1);
    chk("rw_din", din1, 8'hFF);
    chk("rw_busy", {7'd0, bus1.busy}, 8'd0);
    chk("rw_done", {7'd0, bus1.done}, 8'd0);
    chk("rw_rdata", bus1.rdata, 8'h00);
    chk("rw_addr", {6'd0, a1_1, a0_1}, 8'd0);
    rst = 0;
    tick();
    chk("rw_no_done", {7'd0, bus1.done}, 8'd0);

    // Stretched strobe (STROBE_CYCLES=3) read of addr 3
    rsp3_en = 1; rsp3_val = 8'hA5;
    bus3.req = 1; bus3.rw = 1; bus3.addr = 2'd3;
    tick();
    bus3.req = 0;
    chk("s3_setup_nrd", {7'd0, nrd3}, 8'd1);
    chk("s3_setup_ncs", {7'd0, ncs3}, 8'd0);
    tick();
    chk("s3_strobe1_nrd", {7'd0, nrd3}, 8'd0);
    tick();
    chk("s3_strobe2_nrd", {7'd0, nrd3}, 8'd0);
    tick();
    chk("s3_strobe3_nrd", {7'd0, nrd3}, 8'd0);
    chk("s3_strobe3_din", din3, 8'hA5);
    chk("s3_strobe3_addr", {6'd0, a1_3, a0_3}, 8'd3);
    tick();
    chk("s3_hold_nrd", {7'd0, nrd3}, 8'd1);
    chk("s3_hold_done", {7'd0, bus3.done}, 8'd0);
    tick();
    chk("s3_done", {7'd0, bus3.done}, 8'd1);
    chk("s3_rdata", bus3.rdata, 8'hA5);
    chk("s3_ncs", {7'd0, ncs3}, 8'd1);
    rsp3_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ud_counter_bus_host.md
Name: ud_counter_bus_host

Overview:
- Bus initiator for the updowncounter register interface: converts single-cycle command requests into correctly timed chip-select, strobe, address and data-bus cycles on the counter's ncs/nwr/nrd/A0/A1/din pins.
- Also issues the counter's start pulse.
- Sits between the system-side controller or sequencer and the counter peripheral, replacing hand-timed bus stimulus.

Parameters:
- STROBE_CYCLES, 1, cycles nwr/nrd held low per access; legal range is 1 to 15.
- START_CYCLES, 1, cycles start held high per start request; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active high.
- req  input  1  bus access request, sampled only in IDLE.
- rw  input  1  access type: 1 = read, 0 = write; sampled with req.
- addr  input  2  register address {A1,A0}; sampled with req.
- wdata  input  8  write data; sampled with req.
- start_req  input  1  request a start pulse, sampled only in IDLE.
- busy  output  1  high while an access or start pulse is in progress.
- done  output  1  one-cycle pulse when an access or start pulse completes.
- rdata  output  8  captured read data; holds its value until the next read completes.
- ncs  output  1  chip select, active low.
- nwr  output  1  write strobe, active low.
- nrd  output  1  read strobe, active low.
- A0  output  1  address bit 0.
- A1  output  1  address bit 1.
- din  inout  8  counter data bus; driven only during write SETUP/STROBE/HOLD, otherwise high-Z.
- start  output  1  counter start, active high.

Behaviour:
- Reset values: ncs=1, nwr=1, nrd=1, A0=0, A1=0, start=0, busy=0, done=0, rdata=8'h00, din=high-Z, state=IDLE.
- All outputs are registered; din is tri-state controlled by a registered output-enable.
- States: IDLE, SETUP, STROBE, HOLD, PULSE.
- IDLE:
  - req=1 latches rw/addr/wdata and moves to SETUP.
  - Otherwise start_req=1 moves to PULSE.
  - If req and start_req are both high, req wins and start_req is dropped (not queued).
- SETUP (1 cycle):
  - ncs=0; A1:A0=addr; nwr=nrd=1.
  - din is driven with wdata if a write, high-Z if a read.
  - busy=1.
- STROBE (STROBE_CYCLES cycles):
  - Write: nwr=0. Read: nrd=0.
  - ncs, address and write data are held.
  - Cycle counter is 4 bits and counts down to 0.
- Read capture:
  - rdata is loaded from din at the rising edge that ends the last STROBE cycle.
  - rdata is not updated on writes.
- HOLD (1 cycle):
  - Strobes are back to 1; ncs=0; address held.
  - Write data is still driven; din is released at the end of HOLD.
- Access end:
  - Next edge goes to IDLE with done=1 for one cycle.
  - ncs=1, busy=0 in that cycle, and A1:A0 keep the last address.
- PULSE (START_CYCLES cycles):
  - start=1, busy=1, ncs/strobes inactive.
  - Then return to IDLE with done=1 for one cycle.
- Latency:
  - req sampled at edge E0 gives done high during cycle E0+STROBE_CYCLES+3.
  - start_req sampled at E0 gives done high during cycle E0+START_CYCLES+1.
- Back-to-back: a req or start_req present in the done cycle is accepted, because the block is in IDLE. Minimum ncs-high gap between accesses is therefore 1 cycle.
- req or start_req while busy=1 is ignored and has no effect on the current operation.
- nwr and nrd are never low simultaneously; neither is ever low while ncs=1.
- Reset mid-operation: at the next edge all outputs return to reset values, din is released, no done pulse is issued, and rdata is cleared.

Test Plan:
- Write: rst 2 cycles, then req=1, rw=0, addr=0, wdata=8'd4 for 1 cycle (STROBE_CYCLES=1).
  - Required: SETUP with ncs=0, A1A0=00, din=4.
  - Next cycle nwr=0 with din=4.
  - Then HOLD with nwr=1, din=4.
  - Then done=1, ncs=1, din=Z; done occurs 4 cycles after acceptance.
- Register setup sequence: writes of 6, 2, 4 to addr 1, 2, 3, issued back-to-back at each done.
  - Required: three accesses, each with the correct A1A0 and din value during the nwr-low cycle.
  - Exactly one ncs-high cycle between accesses; no overlapping strobes.
- Read: req=1, rw=1, addr=2, with the responder driving 8'h02 only while nrd=0.
  - Required: din is not driven by the host at any time.
  - nrd low for exactly 1 cycle; rdata=8'h02 at done and held afterwards.
- Stretched strobe: STROBE_CYCLES=3, read of addr 3 with the responder driving 8'hA5.
  - Required: nrd low for 3 cycles; done 6 cycles after acceptance; rdata=8'hA5.
- Start and priority:
  - start_req alone (START_CYCLES=1): start=1 for exactly 1 cycle, ncs=1 throughout, then done.
  - req and start_req in the same cycle: only the bus access occurs, and start stays 0.
  - req pulsed during busy: ignored.
- Reset mid-write: assert rst during STROBE.
  - Required: next cycle nwr=1, ncs=1, din=Z, busy=0; no done pulse; rdata=0.
